// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the branch condition unit: condition codes, FSM
// state encoding and the condition evaluator.
package branch_pkg;

  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_UN = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic cond_eval(input logic [2:0] cond, input logic v,
                                     input logic z, input logic n);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_NE: taken = ~z;
      COND_EQ: taken = z;
      COND_GT: taken = ~z & ~n;
      COND_LT: taken = n;
      COND_GE: taken = z | ~n;
      COND_LE: taken = z | n;
      COND_OV: taken = v;
      default: taken = 1'b1;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_cond_unit_if.sv
// Branch request / resolution bus of the branch condition unit, including the
// flag inputs, pending-writer status and the FSM state for debug.
interface branch_cond_unit_if #(parameter int PEND_W = 2);
  import branch_pkg::*;

  // Handshake: a branch transfers on a rising clk edge where br_valid and
  // br_ready are both high; br_valid and br_cond stay stable until then.
  logic              br_valid;
  logic [2:0]        br_cond;
  logic              br_ready;
  logic              flag_wr_issue;
  logic              flag_wr_done;
  logic              ovfl;
  logic              zero;
  logic              sign;
  logic              res_valid;
  logic              res_taken;
  logic [PEND_W-1:0] pend_cnt;
  logic              pend_err;
  state_e            state_dbg;

  modport master (
    output br_valid, br_cond, flag_wr_issue, flag_wr_done, ovfl, zero, sign,
    input  br_ready, res_valid, res_taken, pend_cnt, pend_err, state_dbg
  );

  modport slave (
    input  br_valid, br_cond, flag_wr_issue, flag_wr_done, ovfl, zero, sign,
    output br_ready, res_valid, res_taken, pend_cnt, pend_err, state_dbg
  );
endinterface

// File: rtl/branch_cond_unit_flag_pend_counter.sv
// Saturating up/down count of in-flight flag writers with a sticky error on
// overflow or underflow attempts.
module flag_pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              done,
  output logic [PEND_W-1:0] cnt,
  output logic              err,
  output logic              is_zero,
  output logic              is_one
);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case ({issue, done})
        2'b10: begin
          if (cnt == CNT_MAX) err <= 1'b1;
          else                cnt <= cnt + CNT_ONE;
        end
        2'b01: begin
          if (cnt == '0) err <= 1'b1;
          else           cnt <= cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign is_zero = (cnt == '0);
  assign is_one  = (cnt == CNT_ONE);

endmodule

// File: rtl/branch_cond_unit.sv
// Resolves decoded branch conditions, holding flag-dependent branches until
// their flags are final. FLAG_BYPASS_EN allows resolving in the commit cycle.
module branch_cond_unit
  import branch_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  branch_cond_unit_if.slave  bif
);
`ifdef FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  state_e     state, state_nxt;
  logic [2:0] cond_q, cond_nxt;
  logic [2:0] eval_cond;
  logic       eval;
  logic       is_zero, is_one;
  logic       safe_acc, safe_wait;

  flag_pend_counter #(.PEND_W(PEND_W)) u_pend (
    .clk     (clk),
    .rst     (rst),
    .issue   (bif.flag_wr_issue),
    .done    (bif.flag_wr_done),
    .cnt     (bif.pend_cnt),
    .err     (bif.pend_err),
    .is_zero (is_zero),
    .is_one  (is_one)
  );

  // An issue in the acceptance cycle is younger than the branch. While
  // waiting, an issue alongside the last commit keeps a writer outstanding.
  assign safe_acc  = is_zero | (BYPASS & is_one & bif.flag_wr_done);
  assign safe_wait = is_zero | (BYPASS & is_one & bif.flag_wr_done & ~bif.flag_wr_issue);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cond_q <= COND_NE;
    end else begin
      state  <= state_nxt;
      cond_q <= cond_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cond_nxt  = cond_q;
    eval      = 1'b0;
    eval_cond = cond_q;
    case (state)
      ST_IDLE: begin
        if (bif.br_valid) begin
          if (bif.br_cond == COND_UN || safe_acc) begin
            eval      = 1'b1;
            eval_cond = bif.br_cond;
          end else begin
            state_nxt = ST_WAIT;
            cond_nxt  = bif.br_cond;
          end
        end
      end
      ST_WAIT: begin
        if (safe_wait) begin
          eval      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bif.res_valid <= 1'b0;
      bif.res_taken <= 1'b0;
    end else begin
      bif.res_valid <= eval;
      if (eval) bif.res_taken <= cond_eval(eval_cond, bif.ovfl, bif.zero, bif.sign);
    end
  end

  assign bif.br_ready  = (state == ST_IDLE);
  assign bif.state_dbg = state;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_branch_cond_unit;
`ifdef FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int PEND_W  = 2;
  localparam int CNT_MAX = (1 << PEND_W) - 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  branch_cond_unit_if #(.PEND_W(PEND_W)) bif ();

  branch_cond_unit #(.PEND_W(PEND_W)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_cnt;
  bit         m_err;
  bit         m_wait;
  logic [2:0] m_wcond;
  bit         m_valid;
  bit         m_taken;
  bit         m_ev;
  logic [2:0] m_ev_cond;
  int         m_next;

  function automatic bit ref_cond(input logic [2:0] c, input bit v, input bit z, input bit n);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return (!z) && (!n);
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_err = 0; m_wait = 0; m_wcond = 3'd0; m_valid = 0; m_taken = 0;
    end else begin
      m_ev = 0;
      m_ev_cond = m_wcond;
      if (!m_wait) begin
        if (bif.br_valid) begin
          if (bif.br_cond == 3'd7 || m_cnt == 0 || (BYPASS && m_cnt == 1 && bif.flag_wr_done)) begin
            m_ev = 1; m_ev_cond = bif.br_cond;
          end else begin
            m_wait = 1; m_wcond = bif.br_cond;
          end
        end
      end else if (m_cnt == 0 ||
                   (BYPASS && m_cnt == 1 && bif.flag_wr_done && !bif.flag_wr_issue)) begin
        m_ev = 1; m_wait = 0;
      end
      m_valid = m_ev;
      if (m_ev) m_taken = ref_cond(m_ev_cond, bif.ovfl, bif.zero, bif.sign);
      m_next = m_cnt + int'(bif.flag_wr_issue) - int'(bif.flag_wr_done);
      if (m_next > CNT_MAX) begin m_next = CNT_MAX; m_err = 1; end
      if (m_next < 0)       begin m_next = 0;       m_err = 1; end
      m_cnt = m_next;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #3;
    if (rst) begin
      chk("model_br_ready", int'(bif.br_ready), int'(!m_wait));
      chk("model_res_valid", int'(bif.res_valid), int'(m_valid));
      if (m_valid) chk("model_res_taken", int'(bif.res_taken), int'(m_taken));
      chk("model_pend_cnt", int'(bif.pend_cnt), m_cnt);
      chk("model_pend_err", int'(bif.pend_err), int'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit iss, input bit dn, input bit bv, input logic [2:0] bc);
    bif.flag_wr_issue = iss;
    bif.flag_wr_done  = dn;
    bif.br_valid      = bv;
    bif.br_cond       = bc;
    @(negedge clk);
  endtask

  task automatic wait_res(input string name, input int exp_lat, input bit exp_taken);
    int lat;
    lat = 1;
    while (!bif.res_valid && lat < 6) begin
      cyc(1'b0, 1'b0, 1'b0, 3'd0);
      lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_taken"}, int'(bif.res_taken), int'(exp_taken));
  endtask

  // ---------------- stimulus ----------------
  bit         hold;
  logic [2:0] hc;
  bit         acc;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bif.br_valid = 0; bif.br_cond = 3'd0; bif.flag_wr_issue = 0; bif.flag_wr_done = 0;
    bif.ovfl = 0; bif.zero = 0; bif.sign = 0;
    #1;
    chk("reset_br_ready", int'(bif.br_ready), 1);
    chk("reset_pend_cnt", int'(bif.pend_cnt), 0);
    chk("reset_res_valid", int'(bif.res_valid), 0);
    chk("reset_res_taken", int'(bif.res_taken), 0);
    chk("reset_pend_err", int'(bif.pend_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Resolvable EQ branch
    bif.zero = 1;
    chk("eq_br_ready", int'(bif.br_ready), 1);
    cyc(0, 0, 1, 3'd1);
    chk("eq_res_valid", int'(bif.res_valid), 1);
    chk("eq_res_taken", int'(bif.res_taken), 1);
    cyc(0, 0, 0, 3'd0);
    chk("eq_pulse_end", int'(bif.res_valid), 0);

    // Dependent GT branch behind two writers; flags flip while waiting
    cyc(1, 0, 0, 3'd0);
    cyc(1, 0, 0, 3'd0);
    chk("gt_pend_cnt", int'(bif.pend_cnt), 2);
    cyc(0, 0, 1, 3'd2);
    chk("gt_wait_ready", int'(bif.br_ready), 0);
    cyc(0, 1, 0, 3'd0);
    chk("gt_first_done_valid", int'(bif.res_valid), 0);
    bif.zero = 0; bif.sign = 0;
    cyc(0, 1, 0, 3'd0);
    wait_res("gt_dep", BYPASS ? 1 : 2, 1'b1);

    // Issue and done together at cnt=1 keep the branch waiting
    cyc(1, 0, 0, 3'd0);
    cyc(0, 0, 1, 3'd3);
    cyc(1, 1, 0, 3'd0);
    chk("id_pend_cnt", int'(bif.pend_cnt), 1);
    chk("id_br_ready", int'(bif.br_ready), 0);
    chk("id_res_valid", int'(bif.res_valid), 0);
    bif.sign = 1;
    cyc(0, 1, 0, 3'd0);
    wait_res("lt_dep", BYPASS ? 1 : 2, 1'b1);

    // Saturation and sticky error
    repeat (3) cyc(1, 0, 0, 3'd0);
    chk("sat_cnt3", int'(bif.pend_cnt), 3);
    chk("sat_err_clear", int'(bif.pend_err), 0);
    cyc(1, 0, 0, 3'd0);
    chk("sat_cnt_hold", int'(bif.pend_cnt), 3);
    chk("sat_err_set", int'(bif.pend_err), 1);
    cyc(0, 1, 0, 3'd0);
    chk("sat_cnt_dec", int'(bif.pend_cnt), 2);
    chk("sat_err_sticky", int'(bif.pend_err), 1);

    // Unconditional branch with writers outstanding
    cyc(1, 0, 0, 3'd0);
    bif.zero = 0; bif.sign = 0; bif.ovfl = 0;
    chk("un_br_ready", int'(bif.br_ready), 1);
    cyc(0, 0, 1, 3'd7);
    chk("un_res_valid", int'(bif.res_valid), 1);
    chk("un_res_taken", int'(bif.res_taken), 1);

    // Reset while a branch waits
    cyc(0, 0, 1, 3'd0);
    chk("rw_wait_ready", int'(bif.br_ready), 0);
    bif.br_valid = 0;
    #2 rst = 1'b0;
    #1;
    chk("rw_br_ready", int'(bif.br_ready), 1);
    chk("rw_pend_cnt", int'(bif.pend_cnt), 0);
    chk("rw_pend_err", int'(bif.pend_err), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 3'd0);
      chk("rw_no_result", int'(bif.res_valid), 0);
    end

    // Randomized traffic
    hold = 0;
    hc   = 3'd0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold && $urandom_range(0, 2) == 0) begin
        hold = 1;
        hc   = 3'($urandom_range(0, 7));
      end
      bif.ovfl = 1'($urandom_range(0, 1));
      bif.zero = 1'($urandom_range(0, 1));
      bif.sign = 1'($urandom_range(0, 1));
      acc = hold && bif.br_ready;
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, hold, hc);
      if (acc) hold = 0;
      if ($urandom_range(0, 399) == 0) begin
        bif.br_valid = 0; bif.flag_wr_issue = 0; bif.flag_wr_done = 0;
        hold = 0;
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    cyc(0, 0, 0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Flag consumer for the branch path. It reads the ovfl/zero/sign outputs of the flag register block and resolves the 3-bit branch condition of a decoded branch. It tracks in-flight flag-writing instructions and holds a flag-dependent branch until the flags it depends on are final. It sits between decode (branch request) and PC-select (resolved taken/not-taken).

## Interface
- PEND_W, default 2: width of the pending flag-writer counter; maximum in flight is 2^PEND_W-1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- br_valid  input  1  decode presents a branch; held until accepted.
- br_cond  input  3  condition code; stable while br_valid is high.
- br_ready  output  1  branch accepted this cycle when br_valid is also high.
- flag_wr_issue  input  1  a flag-writing instruction entered the pipe this cycle.
- flag_wr_done  input  1  a flag-writing instruction commits flags this cycle (same as flag_en).
- ovfl, zero, sign  input  1 each  flags from the flag register block (bypassed values).
- res_valid  output  1  one-cycle pulse; res_taken is valid.
- res_taken  output  1  resolved branch direction.
- pend_cnt  output  PEND_W  current count of outstanding flag writers.
- pend_err  output  1  sticky error: counter overflow or underflow attempt.

## Operation
- Condition codes (N=sign, Z=zero, V=ovfl):
  - 000 NE = ~Z
  - 001 EQ = Z
  - 010 GT = ~Z & ~N
  - 011 LT = N
  - 100 GE = Z | ~N
  - 101 LE = Z | N
  - 110 OV = V
  - 111 UN = 1
- Pending counter next value = cnt + issue - done:
  - issue and done in the same cycle: counter unchanged.
  - issue with cnt at max and no done: counter saturates and pend_err is set.
  - done with cnt==0 and no issue: counter holds 0 and pend_err is set.
  - pend_err clears only on reset.
- safe (flags final):
  - With bypass: cnt==0, or cnt==1 & flag_wr_done.
  - Without bypass: see Configuration.
  - flag_wr_issue in the acceptance cycle belongs to a younger instruction and never affects safe.
- FSM states IDLE and WAIT:
  - IDLE: br_ready=1.
    - br_valid with cond==UN, or br_valid & safe: evaluate this cycle and stay in IDLE.
    - br_valid & ~safe: latch cond and go to WAIT.
  - WAIT: br_ready=0. When safe, evaluate the latched cond and return to IDLE.
- Evaluation cycle: res_taken and res_valid are registered at the next edge; res_valid lasts exactly one cycle.
- Back-to-back branches are accepted in consecutive IDLE cycles, giving consecutive res_valid pulses.

## Timing
- Reset values: state IDLE, pend_cnt 0, res_valid 0, res_taken 0, pend_err 0.
- br_ready is combinational from state, so it is 1 during and immediately after reset.
- Resolvable branch: accepted in cycle N, res_valid in cycle N+1.
- Dependent branch: res_valid one cycle after the first safe cycle in WAIT.
- Reset asserted mid-WAIT: the latched branch is dropped and no res_valid is produced.
- Flags are sampled only in the evaluation cycle; flag changes while in WAIT before safe are ignored.

## Configuration
- FLAG_BYPASS_EN defined: safe includes the cnt==1 & flag_wr_done case, and the branch resolves in the commit cycle using the bypassed flags.
- FLAG_BYPASS_EN undefined: safe = cnt==0 only. Dependent branches resolve one cycle later, using the registered flag values.

## Structure
- Shared package branch_pkg holds:
  - condition-code localparams COND_NE…COND_UN.
  - FSM state encoding ST_IDLE, ST_WAIT.
- Sub-module flag_pend_counter: up/down saturating counter producing pend_cnt, pend_err, and the is_zero / is_one flags.
- Top level holds the FSM, the condition evaluator and the output registers.

## Test plan
- Branch with cnt=0, cond=EQ, zero=1 → br_ready=1, res_valid next cycle with res_taken=1.
- Two issues, then a branch GT → WAIT, br_ready=0. Then:
  - done, done with FLAG_BYPASS_EN: res_valid the cycle after the second done, using the flags present in that cycle.
  - Without FLAG_BYPASS_EN: res_valid one cycle later.
- Issue and done in the same cycle with cnt=1 → pend_cnt stays 1, and a pending branch stays in WAIT.
- Three issues with PEND_W=2, then a fourth issue → pend_cnt=3, pend_err=1. A later done gives pend_cnt=2 and pend_err stays 1.
- cond=UN with cnt=3 → resolves immediately, res_taken=1.
- Reset asserted while in WAIT → no res_valid, state IDLE, pend_cnt=0.
